pcla_add: RTL
=============

PCLA_ADD -- requirements
Module: pcla_add

Interface
- REQ-001: Parameter WIDTH, default 32: operand width in bits; SHALL be a multiple of 4*STAGES.
- REQ-002: Parameter STAGES, default 2: number of pipeline segments, which is also the latency in cycles; SHALL be at least 1.
- REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-004: reset  input  1  reset, synchronous and active-high.
- REQ-005: in_valid  input  1  an operand set is presented this cycle.
- REQ-006: in_ready  output  1  the block accepts an operand set this cycle.
- REQ-007: sub  input  1  0 = a+b+ci, 1 = a-b (ci ignored).
- REQ-008: a  input  WIDTH  first operand.
- REQ-009: b  input  WIDTH  second operand.
- REQ-010: ci  input  1  carry-in, used for add only.
- REQ-011: out_valid  output  1  s and ovf hold a valid result.
- REQ-012: out_ready  input  1  downstream consumes the result this cycle.
- REQ-013: s  output  WIDTH+1  result; s[WIDTH] is the carry-out (for sub, 1 means no borrow).
- REQ-014: ovf  output  1  two's-complement signed overflow of the result.

Function
- REQ-015: A transfer SHALL occur on a cycle where in_valid && in_ready are both high, or where out_valid && out_ready are both high.
- REQ-016: in_ready SHALL equal !out_valid || out_ready, and the whole pipeline SHALL advance only on cycles where in_ready is high (global stall).
- REQ-017: Add SHALL compute {cout,sum} = a + b + ci. Sub SHALL compute a + ~b + 1.
- REQ-018: Stage k (k = 0 .. STAGES-1) SHALL compute bits [(k+1)*SEG-1 : k*SEG], where SEG = WIDTH/STAGES, from SEG/4 chained 4-bit CLA groups, using the carry registered from stage k-1. Stage 0 uses ci for add and 1 for sub.
- REQ-019: Unprocessed upper operand bits and completed lower sum bits SHALL be carried forward in skew registers, so that each in-flight operation keeps its own data.
- REQ-020: Each stage SHALL hold a valid bit. A bubble (valid=0) SHALL propagate without changing any output-visible state.
- REQ-021: Latency: a result accepted at cycle t SHALL appear with out_valid=1 at cycle t+STAGES, provided no stall occurs.
- REQ-022: Throughput SHALL be one result per cycle when in_valid=1 and out_ready=1 continuously, with results in acceptance order.
- REQ-023: While out_valid=1 && out_ready=0, s, ovf and all stage registers SHALL hold stable, and no operand SHALL be lost or duplicated.
- REQ-024: A carry out of segment k SHALL reach segment k+1 of the same operation, exactly one cycle later.
- REQ-025: ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1, and SHALL be valid only when out_valid=1.
- REQ-026: An acceptance and an output consumption on the same cycle SHALL both take effect.

Reset
- REQ-027: While reset=1 at a clock edge, all stage valid bits, out_valid, s, ovf and all data and carry registers SHALL become 0.
- REQ-028: Operations in flight when reset is asserted SHALL be discarded, and in_ready SHALL be 1 in the cycle after reset deasserts.
- REQ-029: in_valid SHALL be ignored on cycles where reset=1.

Structure
- REQ-030: Shared package pcla_pkg SHALL hold the constant CLA_GRP=4 and the parameter-legality check (WIDTH % (CLA_GRP*STAGES) == 0).
- REQ-031: The 4-bit CLA group SHALL be the team's existing cla4 cell, instantiated through a generate loop. No other sub-module SHALL be used.

Verification (WIDTH=32, STAGES=2)
- REQ-032: Add 0xFFFFFFFF + 0x00000001, ci=0 -> 2 cycles later s=0x1_00000000, ovf=0.
- REQ-033: Sub 0x80000000 - 0x00000001 -> s=0x1_7FFFFFFF, ovf=1. Sub 5 - 7 -> s=0x0_FFFFFFFE, ovf=0.
- REQ-034: Segment carry: 0x0000FFFF + 0x00000001, ci=0 -> s=0x0_00010000. Also 0x0000FFFF + 0, ci=1 -> s=0x0_00010000.
- REQ-035: Four back-to-back adds with out_ready=1 -> four results on consecutive cycles starting at acceptance+2, in order.
- REQ-036: Pipeline full and out_ready=0 for 3 cycles -> in_ready=0 and s stable. After releasing, remaining results drain in order with none lost.
- REQ-037: Reset asserted with 2 operations in flight -> next cycle out_valid=0, s=0, ovf=0. First result after reset is correct for the first post-reset operands.

Source files
------------

// File: rtl/pcla_add_pkg.sv
// Shared constants and parameter-legality check for the pipelined carry-lookahead adder.
package pcla_pkg;

  localparam int CLA_GRP = 4;

  // Each pipeline segment must split evenly into whole 4-bit CLA groups.
  function automatic bit params_legal(input int width, input int stages);
    return (stages >= 1) && (width > 0) && ((width % (CLA_GRP * stages)) == 0);
  endfunction

endpackage

// File: rtl/pcla_add_cla4.sv
// 4-bit carry-lookahead group: all internal carries and the group carry-out come
// straight from generate/propagate terms, with no ripple inside the group.
module cla4
  import pcla_pkg::*;
(
  input  logic [CLA_GRP-1:0] a,
  input  logic [CLA_GRP-1:0] b,
  input  logic               ci,
  output logic [CLA_GRP-1:0] s,
  output logic               co
);

  logic [CLA_GRP-1:0] g;
  logic [CLA_GRP-1:0] p;
  logic [CLA_GRP-1:0] c;
  logic               grp_g;
  logic               grp_p;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign grp_p = &p;
  assign co    = grp_g | (grp_p & ci);

  assign s = p ^ c;

endmodule

// File: rtl/pcla_add.sv
// Pipelined CLA adder/subtractor: one WIDTH/STAGES-bit segment per stage, carry and
// operands skewed through per-stage registers, global stall on !in_ready.
module pcla_add
  import pcla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   s,
  output logic             ovf
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int NGRP = SEG / CLA_GRP;

  if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
    $error("pcla_add: WIDTH must be a positive multiple of 4*STAGES");
  end

  // Handshake: valid/ready transfer on a cycle where both are high; the output
  // register empties or is consumed, and only then does every stage advance.
  logic             vld_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             cm_q  [STAGES];
  logic             adv;

  assign out_valid = vld_q[STAGES-1];
  assign in_ready  = !out_valid || out_ready;
  assign adv       = in_ready;

  assign s   = {c_q[STAGES-1], s_q[STAGES-1]};
  assign ovf = c_q[STAGES-1] ^ cm_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             src_v;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_s;
    logic             src_c;
    logic [WIDTH-1:0] nxt_s;
    logic [SEG-1:0]   seg_s;
    logic [NGRP:0]    gc;
    logic             nxt_cm;

    if (k == 0) begin : g_first
      // Subtract as a + ~b + 1: invert b once here and force the carry-in.
      assign src_v = in_valid;
      assign src_a = a;
      assign src_b = sub ? ~b : b;
      assign src_c = sub | ci;
      assign src_s = '0;
    end else begin : g_next
      assign src_v = vld_q[k-1];
      assign src_a = a_q[k-1];
      assign src_b = b_q[k-1];
      assign src_c = c_q[k-1];
      assign src_s = s_q[k-1];
    end

    assign gc[0] = src_c;

    for (genvar j = 0; j < NGRP; j++) begin : g_grp
      cla4 u_cla4 (
        .a  (src_a[k*SEG + j*CLA_GRP +: CLA_GRP]),
        .b  (src_b[k*SEG + j*CLA_GRP +: CLA_GRP]),
        .ci (gc[j]),
        .s  (seg_s[j*CLA_GRP +: CLA_GRP]),
        .co (gc[j+1])
      );
    end

    always_comb begin
      nxt_s                 = src_s;
      nxt_s[k*SEG +: SEG]   = seg_s;
    end

    // Carry into the MSB recovered from the sum bit; only meaningful once the top segment is done.
    assign nxt_cm = nxt_s[WIDTH-1] ^ src_a[WIDTH-1] ^ src_b[WIDTH-1];

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        cm_q[k]  <= 1'b0;
      end else if (adv) begin
        vld_q[k] <= src_v;
        // Bubbles leave the data registers untouched so s/ovf never glitch.
        if (src_v) begin
          a_q[k]  <= src_a;
          b_q[k]  <= src_b;
          s_q[k]  <= nxt_s;
          c_q[k]  <= gc[NGRP];
          cm_q[k] <= nxt_cm;
        end
      end
    end
  end

endmodule
